deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits (>=2).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the output buffer depth in words (power of two, >=2).
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all logic samples on its rising edge.
REQ-004 Port rst_i, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-005 Port serial_in_i, input, 1 bit, SHALL carry serial data, MSB first.
REQ-006 Port enable_i, input, 1 bit, SHALL qualify serial_in_i as a valid bit this cycle.
REQ-007 Port start_i, input, 1 bit, SHALL mark the first bit (the MSB) of a word; it is effective only with enable_i high.
REQ-008 Port parallel_out_o, output, DATA_WIDTH bits, SHALL present the word at the head of the buffer.
REQ-009 Port valid_o, output, 1 bit, SHALL be high when parallel_out_o holds a valid word.
REQ-010 Port ready_i, input, 1 bit, SHALL accept the head word when high with valid_o high.
REQ-011 Port overflow_o, output, 1 bit, SHALL pulse for 1 cycle when a completed word is dropped.
REQ-012 Port frame_err_o, output, 1 bit, SHALL pulse for 1 cycle on a framing error.

Function
REQ-013 The FSM SHALL have two states: IDLE (no word in progress) and SHIFT (word partially received).
REQ-014 In IDLE, a cycle with start_i and enable_i high SHALL load serial_in_i as the MSB, set the bit count to 1 and enter SHIFT.
REQ-015 In IDLE, a cycle with enable_i high and start_i low SHALL discard the bit, pulse frame_err_o and stay in IDLE.
REQ-016 In SHIFT, a cycle with enable_i high and start_i low SHALL shift serial_in_i in at the LSB end and increment the bit count.
REQ-017 In SHIFT, cycles with enable_i low SHALL hold the state, shift register and count; gaps of any length are legal.
REQ-018 In SHIFT, a cycle with start_i and enable_i high SHALL discard the partial word, pulse frame_err_o and restart per REQ-014.
REQ-019 The DATA_WIDTH-th qualified bit SHALL complete the word and return the FSM to IDLE in the same cycle.
REQ-020 The completed word SHALL be written to the buffer at the end of the completing cycle; valid_o SHALL be high on the next cycle (latency 1).
REQ-021 The bit counter SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL never exceed DATA_WIDTH.
REQ-022 The buffer SHALL be FIFO ordered; valid_o SHALL equal not-empty; parallel_out_o SHALL be stable while valid_o is high and ready_i is low.
REQ-023 A word completing while the buffer is full and ready_i is low SHALL be dropped; overflow_o SHALL pulse in the cycle after completion, and stored words SHALL be unchanged.
REQ-024 A word completing while the buffer is full and ready_i is high SHALL be accepted: pop and push occur in the same cycle and the buffer stays full.
REQ-025 A push into an empty buffer SHALL not be visible until the following cycle (no combinational bypass).
REQ-026 Back-to-back words (a new start_i in the cycle after a completing bit) SHALL be received with no lost cycle.

Reset
REQ-027 While rst_i is high: FSM SHALL go to IDLE, count and shift register to 0, buffer to empty, and valid_o, overflow_o, frame_err_o to 0.
REQ-028 parallel_out_o SHALL be 0 while the buffer is empty after reset.
REQ-029 Reset asserted mid-word or with words buffered SHALL discard all data with no overflow_o or frame_err_o pulse.
REQ-030 Serial inputs SHALL be ignored in every cycle in which rst_i is high.

Structure
REQ-031 Package serdes_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the default DATA_WIDTH constant shared with the serializer.
REQ-032 The output buffer SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with full/empty outputs and the same clock and reset.

Verification
REQ-033 Single word: start_i with enable_i high and 8 bits of 0xA5, MSB first -> valid_o high 1 cycle after the 8th bit, parallel_out_o=0xA5.
REQ-034 Gapped bits: 0x3C with enable_i low for 3 cycles between bits 4 and 5 -> parallel_out_o=0x3C, no frame_err_o.
REQ-035 Restart: 5 bits of a word, then start_i with 0x81 -> frame_err_o pulses once, only 0x81 is delivered.
REQ-036 Overflow: ready_i low, send 5 words 0x01..0x05 (depth 4) -> words 0x01..0x04 buffered, overflow_o pulses once, then draining yields 0x01..0x04 in order.
REQ-037 Full with ready_i high: buffer full, ready_i high on the completing cycle of 0x77 -> no overflow_o, and 0x77 is the last word drained.
REQ-038 Reset mid-word: rst_i for 1 cycle after 3 bits, then a clean 0xF0 -> only 0xF0 is output, valid_o low during reset.

Source files
------------

// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_pkg
// Purpose  : Types and constants shared by the serializer/deserializer pair.
// Revision : 1.0 - initial release
// ============================================================================
package serdes_pkg;

  // Word width used by both ends of the link unless overridden.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Receive FSM: IDLE = no word in progress, SHIFT = word partially received.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered head output. A push into an
//            empty FIFO becomes visible the following cycle. When full, a
//            push is accepted only if a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    C_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == C_FULL);
  assign w_pop     = rd_en_i && !empty_o;
  assign w_push    = wr_en_i && (!full_o || w_pop);
  // Head is forced to zero while empty so stale storage never shows.
  assign rd_data_o = empty_o ? '0 : r_mem[r_rptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module   : deserializer
// Purpose  : MSB-first serial-to-parallel converter with start-of-word
//            framing, gap tolerance and a small output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  serial_in_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic                  frame_err_o
);

  localparam int            CW     = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_count;
  logic                  r_frame_err;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_last;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;

  // Word as it would look with the current bit shifted in at the LSB.
  assign w_word = {r_shift[DATA_WIDTH-2:0], serial_in_i};
  assign w_last = (r_count == C_LAST);
  // The completing bit pushes the assembled word directly into the FIFO.
  assign w_push = enable_i && !start_i && (r_state == SHIFT) && w_last;

  assign valid_o     = !w_empty;
  assign overflow_o  = r_overflow;
  assign frame_err_o = r_frame_err;

  // Receive FSM: framing, shifting, bit counting and error/overflow pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      // The FIFO drops the push only when full with no pop this cycle.
      r_overflow  <= w_push && w_full && !ready_i;
      if (enable_i) begin
        if (start_i) begin
          // A start while a word is in progress abandons the partial word.
          r_frame_err <= (r_state == SHIFT);
          r_shift     <= {{(DATA_WIDTH-1){1'b0}}, serial_in_i};
          r_count     <= C_ONE;
          r_state     <= SHIFT;
        end else begin
          case (r_state)
            IDLE: begin
              r_frame_err <= 1'b1;
            end
            SHIFT: begin
              if (w_last) begin
                r_shift <= '0;
                r_count <= '0;
                r_state <= IDLE;
              end else begin
                r_shift <= w_word;
                r_count <= r_count + C_ONE;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_push),
    .wr_data_i (w_word),
    .rd_en_i   (ready_i),
    .rd_data_o (parallel_out_o),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

endmodule : deserializer
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializer
// Purpose  : Directed self-checking bench for the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       serial_in_i;
  logic       enable_i;
  logic       start_i;
  logic [7:0] parallel_out_o;
  logic       valid_o;
  logic       ready_i;
  logic       overflow_o;
  logic       frame_err_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_ovf   = 0;
  int n_ferr  = 0;

  deserializer #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .serial_in_i    (serial_in_i),
    .enable_i       (enable_i),
    .start_i        (start_i),
    .parallel_out_o (parallel_out_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .overflow_o     (overflow_o),
    .frame_err_o    (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Count single-cycle pulses, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (overflow_o === 1'b1)  n_ovf++;
    if (frame_err_o === 1'b1) n_ferr++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic st);
    serial_in_i = b;
    start_i     = st;
    enable_i    = 1'b1;
    tick();
    enable_i    = 1'b0;
    start_i     = 1'b0;
    serial_in_i = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i], (i == 7));
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, "_data"}, {24'd0, parallel_out_o}, {24'd0, exp});
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    int ferr0;
    rst_i = 1'b1; serial_in_i = 1'b0; enable_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, parallel_out_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Single word 0xA5 with latency check on the completing bit.
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(w[i], (i == 7));
    check("a5_not_yet", {31'd0, valid_o}, 32'd0);
    send_bit(w[0], 1'b0);
    pop("a5", 8'hA5);
    check("a5_empty", {31'd0, valid_o}, 32'd0);
    check("a5_ferr", n_ferr, 0);

    // Gapped word 0x3C: three idle cycles between bit 4 and bit 5.
    w = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(w[i], (i == 7));
    tick(); tick(); tick();
    check("gap_hold", {31'd0, valid_o}, 32'd0);
    for (int i = 3; i >= 0; i--) send_bit(w[i], 1'b0);
    pop("gap", 8'h3C);
    check("gap_ferr", n_ferr, 0);

    // Restart: five bits, then a fresh 0x81.
    for (int i = 0; i < 5; i++) send_bit(1'b1, (i == 0));
    send_word(8'h81);
    check("rs_ferr", n_ferr, 1);
    pop("rs", 8'h81);
    check("rs_only_one", {31'd0, valid_o}, 32'd0);

    // Overflow: fifth word with ready low is dropped.
    for (int k = 1; k <= 4; k++) send_word(8'(k));
    check("ovf_none_yet", n_ovf, 0);
    send_word(8'h05);
    check("ovf_pulse", {31'd0, overflow_o}, 32'd1);
    tick();
    check("ovf_pulse_end", {31'd0, overflow_o}, 32'd0);
    check("ovf_count", n_ovf, 1);
    pop("ovf1", 8'h01);
    pop("ovf2", 8'h02);
    pop("ovf3", 8'h03);
    pop("ovf4", 8'h04);
    check("ovf_drained", {31'd0, valid_o}, 32'd0);

    // Full with ready high on the completing cycle of 0x77.
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    w = 8'h77;
    for (int i = 7; i >= 1; i--) send_bit(w[i], (i == 7));
    ready_i = 1'b1;
    send_bit(w[0], 1'b0);
    ready_i = 1'b0;
    check("full_rdy_ovf", {31'd0, overflow_o}, 32'd0);
    check("full_rdy_cnt", n_ovf, 1);
    pop("fr1", 8'h22);
    pop("fr2", 8'h33);
    pop("fr3", 8'h44);
    pop("fr4", 8'h77);
    check("fr_drained", {31'd0, valid_o}, 32'd0);

    // Reset with one word buffered and three bits of another in flight.
    ferr0 = n_ferr;
    send_word(8'h5A);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    rst_i = 1'b1; enable_i = 1'b1; start_i = 1'b1; serial_in_i = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_data", {24'd0, parallel_out_o}, 32'd0);
    rst_i = 1'b0; enable_i = 1'b0; start_i = 1'b0; serial_in_i = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    send_word(8'hF0);
    pop("f0", 8'hF0);
    check("f0_only", {31'd0, valid_o}, 32'd0);
    check("rst_no_ferr", n_ferr, ferr0);
    check("rst_no_ovf", n_ovf, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_deserializer
`default_nettype wire
